cod8x3_seq: RTL and testbench
=============================

Name: cod8x3_seq

Overview:
- Sequential 8-to-3 encoder; the inverse of the team's 3-to-8 one-hot decoder.
- Accepts an 8-bit vector through a valid/ready handshake, then emits the 3-bit binary index of every set bit, one per handshake beat.
- Ordering is lowest index first by default.
- Sits between request/flag vectors (decoder outputs, interrupt lines) and logic that consumes binary codes.

Parameters:
- MSB_PRIMEIRO, 0: scan order. 0 = lowest set bit first; 1 = highest set bit first.

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- habilita  input  1  enable; low blocks capture and aborts an in-progress scan
- in_valid  input  1  vector on `in` is offered
- in  input  8  vector to encode
- in_ready  output  1  block can accept a vector this cycle
- out  output  3  binary index of current selected bit
- out_valid  output  1  `out` holds a valid code
- out_ready  input  1  consumer accepts the current code
- ultimo  output  1  current beat is the last for the captured vector
- vazio  output  1  captured vector was all zeros; qualifies the single beat

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high, sampled on the rising edge.
- Reset values: state=OCIOSO, pendente=8'h00, out=3'd0, out_valid=0, ultimo=0, vazio=0, in_ready=0.
  - in_ready is 0 only during the reset cycle itself.
  - in_ready rises the first cycle after rst falls, if habilita=1.
- Timing: all outputs are driven from registers; there is no combinational path from any input to any output.
- States: OCIOSO, VARRE.
- OCIOSO:
  - in_ready = habilita.
  - Capture occurs when in_valid & in_ready at an edge: pendente <= in; move to VARRE.
  - out_valid rises on the next cycle (capture at edge N → out_valid=1 after edge N).
- VARRE:
  - out = index of the selected set bit of pendente: lowest if MSB_PRIMEIRO=0, highest if MSB_PRIMEIRO=1.
  - out_valid=1.
  - ultimo=1 when pendente has exactly one set bit.
  - in_ready=0 throughout VARRE.
  - Accept: on an edge with out_valid & out_ready, clear the selected bit in pendente.
    - If ultimo was 1, go to OCIOSO.
    - Otherwise present the next index on the following cycle.
  - Back-pressure: while out_ready=0, out, ultimo and vazio are held stable and pendente is unchanged.
- Zero vector: capturing in=8'h00 produces exactly one beat with out=3'd0, vazio=1, ultimo=1. Its acceptance returns the block to OCIOSO.
- Throughput: one code per cycle under continuous out_ready. A vector with k set bits takes k beats; an all-zero vector takes 1 beat.
- Back-to-back vectors:
  - The earliest next capture is the cycle after the last beat is accepted, because in_ready is registered.
  - Minimum gap is 1 idle cycle between vectors.
- habilita=0 during VARRE:
  - Abort at the next edge: pendente <= 0, out_valid <= 0, ultimo <= 0, vazio <= 0, state <= OCIOSO.
  - A beat handshaken on that same edge counts as delivered; the abort still takes effect.
- habilita=0 in OCIOSO: in_ready=0 and in_valid is ignored.
- Reset mid-scan: rst has priority over all events. The next cycle is the reset state and pendente is discarded.
- Outputs when out_valid=0: out, ultimo and vazio are driven 0.
- Encoding rule: out = binary position, bit 0 → 3'd0 … bit 7 → 3'd7. A one-hot input round-trips through the team decoder to the original vector.

Test Plan:
- Reset: rst=1 for 2 cycles, then release with habilita=1 → out_valid=0, out=0, pendente=0 during reset; in_ready=1 the cycle after release.
- Multi-bit vector: in=8'b1010_0110, out_ready=1 constantly, MSB_PRIMEIRO=0 → out sequence 1,2,5,7 on consecutive cycles; ultimo=1 only with 7; back to OCIOSO.
- Same vector, MSB_PRIMEIRO=1 → sequence 7,5,2,1.
- Zero vector and back-pressure:
  - in=8'h00 → one beat with out=0, vazio=1, ultimo=1.
  - in=8'h81 with out_ready low for 3 cycles → out=0 held stable with out_valid=1 throughout, then 0 followed by 7 once out_ready=1.
- Abort: in=8'hFF, after 2 accepted beats drop habilita → out_valid=0 next cycle; in_ready stays 0 until habilita returns; re-enable and capture 8'h10 → single beat out=4, ultimo=1.
- Exhaustive one-hot round-trip: for i in 0..7 send in=1<<i → out=i, ultimo=1, vazio=0. Feeding out to the 3-to-8 decoder with habilita=1 reproduces 1<<i. Also assert rst mid-scan of 8'hFF → scan discarded, state OCIOSO next cycle.

Source files
------------

// File: rtl/cod8x3_seq.sv
// cod8x3_seq: sequential 8-to-3 encoder, emits the index of every set bit of a captured vector, one per handshake beat
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   habilita        enable; low blocks capture and aborts a scan in progress
//   in_valid, in    offered 8-bit vector; in_ready says it can be taken this cycle
//   out, out_valid  3-bit index of the selected set bit and its qualifier
//   out_ready       consumer accepts the current code
//   ultimo          current beat is the last for the captured vector
//   vazio           captured vector was all zeros (single beat with out=0)
// MSB_PRIMEIRO: 0 = lowest set bit first, 1 = highest set bit first
module cod8x3_seq #(
    parameter int MSB_PRIMEIRO = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       habilita,
    input  logic       in_valid,
    input  logic [7:0] in,
    output logic       in_ready,
    output logic [2:0] out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       ultimo,
    output logic       vazio
);
    typedef enum logic {OCIOSO, VARRE} estado_t;
    estado_t estado, estado_nx;
    logic [7:0] pendente, pendente_nx;
    // Later matches overwrite earlier ones, so the scan runs toward the preferred end.
    function automatic logic [2:0] seleciona(input logic [7:0] v);
        logic [2:0] j;
        seleciona = 3'd0;
        for (int i = 0; i < 8; i++) begin
            j = 3'(MSB_PRIMEIRO != 0 ? i : 7 - i);
            if (v[j]) seleciona = j;
        end
    endfunction
    // out always holds the selected index while scanning, so it doubles as the bit to clear.
    always_comb begin
        estado_nx = estado;
        pendente_nx = pendente;
        if (estado == OCIOSO) begin
            if (habilita && in_ready && in_valid) begin
                estado_nx = VARRE;
                pendente_nx = in;
            end
        end else if (!habilita) begin
            estado_nx = OCIOSO;
            pendente_nx = 8'h00;
        end else if (out_valid && out_ready) begin
            pendente_nx = pendente & ~(8'd1 << out);
            estado_nx = ultimo ? OCIOSO : VARRE;
        end
    end
    // Outputs are computed from the next state so they stay registered yet line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= OCIOSO;
            pendente <= 8'h00;
            out <= 3'd0;
            out_valid <= 1'b0;
            ultimo <= 1'b0;
            vazio <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            estado <= estado_nx;
            pendente <= pendente_nx;
            out_valid <= estado_nx == VARRE;
            out <= estado_nx == VARRE ? seleciona(pendente_nx) : 3'd0;
            ultimo <= estado_nx == VARRE && $countones(pendente_nx) <= 1;
            vazio <= estado_nx == VARRE && pendente_nx == 8'h00;
            in_ready <= estado_nx == OCIOSO && habilita;
        end
    end
endmodule

// File: tb/tb_cod8x3_seq.sv
// tb_cod8x3_seq: randomized self-checking bench for both scan orders of cod8x3_seq
module tb_cod8x3_seq;
    logic clk = 1'b0;
    logic rst, habilita, in_valid, out_ready;
    logic [7:0] din;
    logic d0_in_ready, d0_out_valid, d0_ultimo, d0_vazio;
    logic d1_in_ready, d1_out_valid, d1_ultimo, d1_vazio;
    logic [2:0] d0_out, d1_out;
    int vectors = 0;
    int miscompares = 0;
    int exp_lo[$];
    int exp_hi[$];

    always #5 clk = ~clk;

    cod8x3_seq #(.MSB_PRIMEIRO(0)) d0 (
        .clk(clk), .rst(rst), .habilita(habilita), .in_valid(in_valid), .in(din),
        .in_ready(d0_in_ready), .out(d0_out), .out_valid(d0_out_valid),
        .out_ready(out_ready), .ultimo(d0_ultimo), .vazio(d0_vazio)
    );
    cod8x3_seq #(.MSB_PRIMEIRO(1)) d1 (
        .clk(clk), .rst(rst), .habilita(habilita), .in_valid(in_valid), .in(din),
        .in_ready(d1_in_ready), .out(d1_out), .out_valid(d1_out_valid),
        .out_ready(out_ready), .ultimo(d1_ultimo), .vazio(d1_vazio)
    );

    // Observed tuple per instance: {out_valid, out, ultimo, vazio, in_ready}
    task automatic run_vec(input logic [7:0] v, input int first_stall, input bit rnd_stall);
        int t = 0;
        logic [6:0] e0, e1;
        while (!d0_in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (d0_in_ready !== 1'b1 || d1_in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL in_ready_wait v=%h: got %b/%b expected 1/1", v, d0_in_ready, d1_in_ready);
        end
        exp_lo = {};
        exp_hi = {};
        for (int i = 0; i < 8; i++)
            if (v[i]) begin
                exp_lo.push_back(i);
                exp_hi.push_front(i);
            end
        if (v == 8'h00) begin
            exp_lo.push_back(0);
            exp_hi.push_back(0);
        end
        din = v;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        din = 8'($urandom);
        for (int b = 0; b < exp_lo.size(); b++) begin
            int hold = b == 0 ? first_stall : (rnd_stall ? int'($urandom_range(0, 2)) : 0);
            for (int h = 0; h <= hold; h++) begin
                e0 = {1'b1, 3'(exp_lo[b]), b == exp_lo.size() - 1, v == 8'h00, 1'b0};
                e1 = {1'b1, 3'(exp_hi[b]), b == exp_hi.size() - 1, v == 8'h00, 1'b0};
                vectors++;
                if ({d0_out_valid, d0_out, d0_ultimo, d0_vazio, d0_in_ready} !== e0) begin
                    miscompares++;
                    $display("FAIL beat_lsb v=%h b=%0d: got %b expected %b", v, b,
                             {d0_out_valid, d0_out, d0_ultimo, d0_vazio, d0_in_ready}, e0);
                end
                vectors++;
                if ({d1_out_valid, d1_out, d1_ultimo, d1_vazio, d1_in_ready} !== e1) begin
                    miscompares++;
                    $display("FAIL beat_msb v=%h b=%0d: got %b expected %b", v, b,
                             {d1_out_valid, d1_out, d1_ultimo, d1_vazio, d1_in_ready}, e1);
                end
                if ($countones(v) == 1 && h == 0) begin
                    vectors++;
                    if ((8'd1 << d0_out) !== v) begin
                        miscompares++;
                        $display("FAIL decode_roundtrip: got %h expected %h", 8'd1 << d0_out, v);
                    end
                end
                out_ready = h == hold;
                @(negedge clk);
            end
        end
        out_ready = 1'b0;
        vectors++;
        if ({d0_out_valid, d0_out, d0_ultimo, d0_vazio, d0_in_ready} !== {6'b0, habilita} ||
            {d1_out_valid, d1_out, d1_ultimo, d1_vazio, d1_in_ready} !== {6'b0, habilita}) begin
            miscompares++;
            $display("FAIL end_of_vector v=%h: got %b/%b expected %b", v,
                     {d0_out_valid, d0_out, d0_ultimo, d0_vazio, d0_in_ready},
                     {d1_out_valid, d1_out, d1_ultimo, d1_vazio, d1_in_ready}, {6'b0, habilita});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        habilita = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        din = 8'h00;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            vectors++;
            if ({d0_out_valid, d0_out, d0_ultimo, d0_vazio, d0_in_ready} !== 7'd0 ||
                {d1_out_valid, d1_out, d1_ultimo, d1_vazio, d1_in_ready} !== 7'd0) begin
                miscompares++;
                $display("FAIL reset_state: got %b/%b expected 0000000",
                         {d0_out_valid, d0_out, d0_ultimo, d0_vazio, d0_in_ready},
                         {d1_out_valid, d1_out, d1_ultimo, d1_vazio, d1_in_ready});
            end
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (d0_in_ready !== 1'b1 || d0_out_valid !== 1'b0 || d1_in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b expected 1 0", d0_in_ready, d0_out_valid);
        end
    endtask

    task automatic test_multibit();
        run_vec(8'b1010_0110, 0, 1'b0);
    endtask

    task automatic test_zero_backpressure();
        run_vec(8'h00, 0, 1'b0);
        run_vec(8'h81, 3, 1'b0);
    endtask

    task automatic test_abort();
        din = 8'hFF;
        in_valid = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        vectors++;
        if (d0_out !== 3'd2 || d1_out !== 3'd5 || d0_out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_third_beat: got %0d/%0d expected 2/5", d0_out, d1_out);
        end
        habilita = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        out_ready = 1'b0;
        vectors++;
        if ({d0_out_valid, d0_out, d0_ultimo, d0_vazio, d0_in_ready} !== 7'd0 ||
            {d1_out_valid, d1_out, d1_ultimo, d1_vazio, d1_in_ready} !== 7'd0) begin
            miscompares++;
            $display("FAIL abort_state: got %b/%b expected 0000000",
                     {d0_out_valid, d0_out, d0_ultimo, d0_vazio, d0_in_ready},
                     {d1_out_valid, d1_out, d1_ultimo, d1_vazio, d1_in_ready});
        end
        din = 8'h55;
        in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            vectors++;
            if (d0_in_ready !== 1'b0 || d0_out_valid !== 1'b0 || d1_out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL disabled_idle: got in_ready=%b out_valid=%b expected 0 0", d0_in_ready, d0_out_valid);
            end
        end
        in_valid = 1'b0;
        habilita = 1'b1;
        @(negedge clk);
        vectors++;
        if (d0_in_ready !== 1'b1 || d0_out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reenable: got in_ready=%b out_valid=%b expected 1 0", d0_in_ready, d0_out_valid);
        end
        run_vec(8'h10, 0, 1'b0);
    endtask

    task automatic test_onehot_reset_midscan();
        for (int i = 0; i < 8; i++) run_vec(8'd1 << i, 0, 1'b0);
        din = 8'hFF;
        in_valid = 1'b1;
        out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        vectors++;
        if ({d0_out_valid, d0_out, d0_ultimo, d0_vazio, d0_in_ready} !== 7'd0 ||
            {d1_out_valid, d1_out, d1_ultimo, d1_vazio, d1_in_ready} !== 7'd0) begin
            miscompares++;
            $display("FAIL reset_midscan: got %b/%b expected 0000000",
                     {d0_out_valid, d0_out, d0_ultimo, d0_vazio, d0_in_ready},
                     {d1_out_valid, d1_out, d1_ultimo, d1_vazio, d1_in_ready});
        end
        @(negedge clk);
        run_vec(8'h03, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 40; n++) begin
            logic [7:0] v = $urandom_range(0, 4) == 0 ? 8'h00 : 8'($urandom);
            run_vec(v, int'($urandom_range(0, 2)), 1'b1);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_multibit();
        test_zero_backpressure();
        test_abort();
        test_onehot_reset_midscan();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
